// File: rtl/producer_ctrl_pkg.sv
// Shared types and helpers for the producer run controller.
// The state encoding is fixed so that other blocks in the codebase
// can decode it from waveforms or debug taps.
`timescale 1ns/1ps

package producer_ctrl_pkg;

    // Controller states (Moore, registered)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Width of an index that addresses n items; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/producer_ctrl_start_decode.sv
// Start-vector decoder: flags when exactly one start bit is high and
// encodes the position of that bit. The index is only meaningful while
// single_hot is set; with several bits high it is an OR of their indices.
`timescale 1ns/1ps

module start_decode
    import producer_ctrl_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int CW   = idx_width(N_CH)
) (
    input  logic [N_CH-1:0] start,
    output logic            single_hot,
    output logic [CW-1:0]   idx
);

    genvar gi, gb;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
    assign single_hot = (start != '0) && ((start & (start - N_CH'(1))) == '0);

    // Each index bit is the OR of the start bits whose channel number has that bit set
    generate
        for (gb = 0; gb < CW; gb++) begin : g_idx_bit
            logic [N_CH-1:0] sel_mask;
            for (gi = 0; gi < N_CH; gi++) begin : g_ch
                localparam logic [31:0] CH_NUM = gi;
                assign sel_mask[gi] = CH_NUM[gb];
            end
            assign idx[gb] = |(start & sel_mask);
        end
    endgenerate

endmodule

// File: rtl/producer_ctrl.sv
// Run controller for N_CH data producers sharing one FIFO write port.
// Grants one producer at a time, throttles it on FIFO full, drains the
// FIFO after a stop and reports the granted channel.
// Optional feature: define PRODUCER_CTRL_DRAIN_TIMEOUT_EN to abandon a
// drain after TO_CYCLES DRAIN cycles and pulse drain_timeout; without it
// DRAIN waits indefinitely for the FIFO to empty.
`timescale 1ns/1ps

module producer_ctrl
    import producer_ctrl_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int W_DATA    = 16,
    parameter int TO_CYCLES = 1024,
    parameter int CW        = idx_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        start,
    input  logic                   stop,
    input  logic                   buffer_full,
    input  logic                   buffer_empty,
    input  logic                   data_valid,
    input  logic [N_CH*W_DATA-1:0] ch_data,
    input  logic [N_CH-1:0]        ch_valid,
    output logic [N_CH-1:0]        en,
    output logic [CW-1:0]          active_ch,
    output logic                   busy,
    output logic [W_DATA-1:0]      wr_data,
    output logic                   wr_en,
    output logic                   drain_timeout
);

    genvar gi;

    state_e            state_q, state_d;
    logic [CW-1:0]     active_ch_q, active_ch_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic              drain_timeout_q, drain_timeout_d;

    logic              start_single;
    logic [CW-1:0]     start_idx;
    logic              drain_empty;
    logic              drain_expired;

    logic [W_DATA-1:0] gated_data [N_CH];

    start_decode #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_start_decode (
        .start      (start),
        .single_hot (start_single),
        .idx        (start_idx)
    );

    // FIFO is fully drained only once the read side has also let go of its word
    assign drain_empty = buffer_empty & ~data_valid;

`ifdef PRODUCER_CTRL_DRAIN_TIMEOUT_EN
    localparam int TW = idx_width(TO_CYCLES);

    logic [TW-1:0] drain_cnt_q, drain_cnt_d;

    // Count DRAIN cycles; held at zero elsewhere so each DRAIN entry starts from zero
    always_comb begin
        drain_cnt_d = '0;
        if (state_q == DRAIN) begin
            drain_cnt_d = drain_cnt_q + TW'(1);
        end
    end

    // Drain cycle counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign drain_expired = (state_q == DRAIN) && (drain_cnt_q == TW'(TO_CYCLES - 1));
`else
    assign drain_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop outranks the full/not-full throttle decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_single) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (buffer_full) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (!buffer_full) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drain_empty || drain_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: channel latch on grant and the timeout pulse (empty exit wins a tie)
    always_comb begin
        active_ch_d = active_ch_q;
        if ((state_q == IDLE) && start_single) begin
            active_ch_d = start_idx;
        end
        drain_timeout_d = (state_q == DRAIN) && drain_expired && !drain_empty;
    end

    // Enable is decoded from the next state so it lines up with the registered state
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_en
            assign en_d[gi] = (state_d == RUN) && (active_ch_d == CW'(gi));
        end
    endgenerate

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_ch_q     <= '0;
            en_q            <= '0;
            drain_timeout_q <= 1'b0;
        end else begin
            active_ch_q     <= active_ch_d;
            en_q            <= en_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    // Per-channel data gated by its enable; at most one enable is ever high
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_gate
            assign gated_data[gi] = en_q[gi] ? ch_data[gi*W_DATA +: W_DATA] : '0;
        end
    endgenerate

    // Write-data mux as an OR of the gated channel slices
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_data = wr_data | gated_data[i];
        end
    end

    assign wr_en         = |(en_q & ch_valid);
    assign en            = en_q;
    assign active_ch     = active_ch_q;
    assign busy          = (state_q != IDLE);
    assign drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_producer_ctrl.sv
// Bench for producer_ctrl: directed checks with literal expectations, then
// randomized traffic compared every cycle against a flag-based model.
// A second 4-channel instance exercises asynchronous reset mid-run.
`timescale 1ns/1ps

module tb_producer_ctrl;

    localparam int N_CH = 2;
    localparam int W    = 16;
    localparam int TO   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-channel DUT signals
    logic           rst;
    logic [1:0]     start;
    logic           stop, buffer_full, buffer_empty, data_valid;
    logic [31:0]    ch_data;
    logic [1:0]     ch_valid;
    logic [1:0]     en;
    logic [0:0]     active_ch;
    logic           busy;
    logic [15:0]    wr_data;
    logic           wr_en, drain_timeout;

    // 4-channel DUT signals
    logic           rst4;
    logic [3:0]     start4;
    logic           stop4, full4, empty4, dv4;
    logic [63:0]    ch_data4;
    logic [3:0]     ch_valid4;
    logic [3:0]     en4;
    logic [1:0]     active4;
    logic           busy4;
    logic [15:0]    wr_data4;
    logic           wr_en4, to4;

    producer_ctrl #(.N_CH(N_CH), .W_DATA(W), .TO_CYCLES(TO)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_valid(data_valid),
        .ch_data(ch_data), .ch_valid(ch_valid), .en(en), .active_ch(active_ch),
        .busy(busy), .wr_data(wr_data), .wr_en(wr_en), .drain_timeout(drain_timeout)
    );

    producer_ctrl #(.N_CH(4), .W_DATA(W), .TO_CYCLES(TO)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .stop(stop4),
        .buffer_full(full4), .buffer_empty(empty4), .data_valid(dv4),
        .ch_data(ch_data4), .ch_valid(ch_valid4), .en(en4), .active_ch(active4),
        .busy(busy4), .wr_data(wr_data4), .wr_en(wr_en4), .drain_timeout(to4)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Behavioural model: granted / producing / draining flags plus the channel
    bit m_busy, m_run, m_drain, m_to;
    int m_ch, m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_run   = 1'b0;
        m_drain = 1'b0;
        m_to    = 1'b0;
        m_ch    = 0;
        m_cnt   = 0;
    endtask

    // One clock edge of the model, from the inputs that were presented at the edge
    task automatic model_step();
        m_to = 1'b0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if ($countones(start) == 1) begin
                m_busy = 1'b1;
                m_run  = 1'b1;
                for (int i = 0; i < N_CH; i++) if (start[i]) m_ch = i;
            end
        end else if (m_drain) begin
            if (buffer_empty && !data_valid) begin
                m_busy  = 1'b0;
                m_drain = 1'b0;
            end
`ifdef PRODUCER_CTRL_DRAIN_TIMEOUT_EN
            else if (m_cnt == TO - 1) begin
                m_busy  = 1'b0;
                m_drain = 1'b0;
                m_to    = 1'b1;
            end else begin
                m_cnt++;
            end
`endif
        end else if (stop) begin
            m_drain = 1'b1;
            m_run   = 1'b0;
            m_cnt   = 0;
        end else begin
            m_run = !buffer_full;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Every-cycle comparison of the 2-channel DUT against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_en", en, m_run ? (64'd1 << m_ch) : 64'd0);
            chk("cmp_active_ch", active_ch, m_ch);
            chk("cmp_busy", busy, m_busy);
            chk("cmp_drain_timeout", drain_timeout, m_to);
            chk("cmp_wr_en", wr_en, m_run && ch_valid[m_ch]);
            chk("cmp_wr_data", wr_data, m_run ? ch_data[m_ch*16 +: 16] : 16'h0);
        end
    end

    initial begin
        int r;
        bit prev_busy;

        rst = 1'b1; start = '0; stop = 1'b0; buffer_full = 1'b0;
        buffer_empty = 1'b1; data_valid = 1'b0;
        ch_data = 32'hBEEF_1234; ch_valid = 2'b11;
        rst4 = 1'b1; start4 = '0; stop4 = 1'b0; full4 = 1'b0; empty4 = 1'b1; dv4 = 1'b0;
        ch_data4 = '0; ch_valid4 = '0;
        model_reset();

        repeat (3) cyc();
        chk("rst_en", en, 2'b00);
        chk("rst_active_ch", active_ch, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_data", wr_data, 16'h0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_drain_timeout", drain_timeout, 1'b0);
        rst = 1'b0;
        chk_on = 1'b1;
        cyc();

        // Grant channel 0
        ch_valid = 2'b01;
        start = 2'b01;
        cyc();
        start = 2'b00;
        $display("txn: start 01 -> en %b active %0d wr_data %h", en, active_ch, wr_data);
        chk("grant_en", en, 2'b01);
        chk("grant_active_ch", active_ch, 1'b0);
        chk("grant_busy", busy, 1'b1);
        chk("grant_wr_en", wr_en, 1'b1);
        chk("grant_wr_data", wr_data, 16'h1234);

        // Backpressure for five cycles
        buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("full_en", en, 2'b00);
            chk("full_busy", busy, 1'b1);
        end
        buffer_full = 1'b0;
        cyc();
        $display("txn: buffer_full released -> en %b", en);
        chk("resume_en", en, 2'b01);

        // Start while running is ignored
        start = 2'b10;
        cyc();
        start = 2'b00;
        $display("txn: start 10 in RUN -> active %0d", active_ch);
        chk("ign_start_active_ch", active_ch, 1'b0);
        chk("ign_start_en", en, 2'b01);

        // Stop beats buffer_full; drain held by data_valid
        stop = 1'b1; buffer_full = 1'b1;
        cyc();
        stop = 1'b0; buffer_full = 1'b0; buffer_empty = 1'b1; data_valid = 1'b1;
        $display("txn: stop+full -> en %b busy %0d", en, busy);
        chk("stop_en", en, 2'b00);
        chk("stop_busy", busy, 1'b1);
        chk("stop_wr_data", wr_data, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("drain_hold_busy", busy, 1'b1);
        end
        data_valid = 1'b0;
        cyc();
        $display("txn: drain empty -> busy %0d", busy);
        chk("drain_done_busy", busy, 1'b0);
        chk("drain_done_timeout", drain_timeout, 1'b0);

        // Two start bits in IDLE are ignored
        start = 2'b11;
        cyc();
        start = 2'b00;
        $display("txn: start 11 in IDLE -> busy %0d en %b", busy, en);
        chk("multi_start_busy", busy, 1'b0);
        chk("multi_start_en", en, 2'b00);

        // Drain with FIFO never emptying
        start = 2'b10;
        cyc();
        start = 2'b00;
        chk("grant1_active_ch", active_ch, 1'b1);
        chk("grant1_en", en, 2'b10);
        stop = 1'b1;
        cyc();
        stop = 1'b0; buffer_empty = 1'b0; data_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cyc();
`ifdef PRODUCER_CTRL_DRAIN_TIMEOUT_EN
            chk("to_busy", busy, (i < 8) ? 1'b1 : 1'b0);
            chk("to_pulse", drain_timeout, (i == 8) ? 1'b1 : 1'b0);
`else
            chk("noto_busy", busy, 1'b1);
            chk("noto_pulse", drain_timeout, 1'b0);
`endif
        end
        $display("txn: stuck drain -> busy %0d", busy);
        buffer_empty = 1'b1;
        cyc();
        chk("after_stuck_busy", busy, 1'b0);

        // Randomized traffic
        prev_busy = m_busy;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            start        = (r < 6) ? 2'b01 : (r < 12) ? 2'b10 : (r < 14) ? 2'b11 : 2'b00;
            stop         = ($urandom_range(0, 99) < 4);
            buffer_full  = ($urandom_range(0, 99) < 30);
            buffer_empty = ($urandom_range(0, 99) < 50);
            data_valid   = ($urandom_range(0, 99) < 40);
            ch_data      = $urandom;
            ch_valid     = 2'($urandom);
            cyc();
            if (m_busy && !prev_busy) $display("txn: random grant ch %0d at step %0d", m_ch, i);
            if (m_to) $display("txn: random drain timeout at step %0d", i);
            prev_busy = m_busy;
            if (i == 1500) begin
                rst = 1'b1;
                model_reset();
                cyc();
                rst = 1'b0;
                prev_busy = 1'b0;
                $display("txn: async reset during random traffic");
            end
        end
        start = '0; stop = 1'b0; buffer_full = 1'b0;

        // 4-channel instance: grant channel 3, then reset between edges
        rst4 = 1'b0;
        cyc();
        ch_data4 = 64'hCAFE_0003_0002_0001;
        ch_valid4 = 4'b1000;
        start4 = 4'b1000;
        cyc();
        start4 = 4'b0000;
        $display("txn: 4ch start 1000 -> en %b active %0d", en4, active4);
        chk("ch4_en", en4, 4'b1000);
        chk("ch4_active_ch", active4, 2'd3);
        chk("ch4_wr_data", wr_data4, 16'hCAFE);
        chk("ch4_wr_en", wr_en4, 1'b1);
        cyc();
        rst4 = 1'b1;
        #1;
        $display("txn: 4ch async reset -> en %b active %0d busy %0d", en4, active4, busy4);
        chk("ch4_rst_en", en4, 4'b0000);
        chk("ch4_rst_active_ch", active4, 2'd0);
        chk("ch4_rst_busy", busy4, 1'b0);
        chk("ch4_rst_wr_en", wr_en4, 1'b0);
        chk("ch4_rst_timeout", to4, 1'b0);
        cyc();

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/producer_ctrl.md
# producer_ctrl

Parametrised run controller for N_CH data producers (Fibonacci, timer, and later generators) that share one clock-domain-crossing FIFO wrapper. It accepts per-channel start pulses and a common stop pulse, and grants exactly one producer at a time. It throttles the producer on FIFO backpressure and drains the FIFO before returning to idle. It also muxes the granted channel's data onto the FIFO write port and reports the active channel to the display manager.

## Interface
Parameters:
- N_CH, 2: number of producer channels (≥1).
- W_DATA, 16: producer data width.
- TO_CYCLES, 1024: drain timeout in clk cycles (≥2); used only with PRODUCER_CTRL_DRAIN_TIMEOUT_EN.
- CW, derived as max(1, $clog2(N_CH)): channel index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  N_CH  per-channel start request; single-cycle pulses, already edge-detected.
- stop  in  1  stop request; single-cycle pulse.
- buffer_full  in  1  FIFO full, synchronous to clk.
- buffer_empty  in  1  FIFO empty, synchronous to clk.
- data_valid  in  1  FIFO read side still presenting a word.
- ch_data  in  N_CH*W_DATA  concatenated producer outputs; channel i is bits [i*W_DATA +: W_DATA].
- ch_valid  in  N_CH  per-channel output-valid.
- en  out  N_CH  one-hot producer enable, registered.
- active_ch  out  CW  index of the granted channel, registered.
- busy  out  1  high in any state other than IDLE.
- wr_data  out  W_DATA  muxed FIFO write data.
- wr_en  out  1  FIFO write enable.
- drain_timeout  out  1  one-cycle pulse when a drain is abandoned.

## Operation
- States (Moore, registered): IDLE, RUN, WAIT, DRAIN.
- IDLE:
  - If exactly one start bit is high, latch its index into active_ch and go to RUN.
  - If zero or more than one start bit is high, stay in IDLE.
  - stop is ignored in IDLE.
- RUN:
  - If stop, go to DRAIN.
  - Else if buffer_full, go to WAIT.
  - Otherwise stay.
- WAIT:
  - If stop, go to DRAIN.
  - Else if ~buffer_full, go to RUN.
  - Otherwise stay.
- DRAIN:
  - If buffer_empty & ~data_valid, go to IDLE.
  - Timeout behaviour: see Configuration.
- stop has priority over buffer_full or ~buffer_full in the same cycle.
- start is ignored outside IDLE. active_ch changes only on the IDLE→RUN transition.
- en[active_ch]=1 only while the state is RUN. All other en bits are 0 in every state.
- wr_data = ch_data slice for active_ch when en[active_ch]=1, else 0.
- wr_en = en[active_ch] & ch_valid[active_ch]. This is combinational from the registered en.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE; en 0; active_ch 0; busy 0; wr_data 0; wr_en 0; drain_timeout 0.
- A start pulse sampled at edge k gives state RUN and the en bit high after edge k.
- A buffer_full sampled at edge k drops en after edge k. Producers must tolerate one further write being in flight; the FIFO's almost-full margin absorbs it.
- A stop sampled at edge k drops en after edge k.
- In DRAIN, an empty condition sampled at edge k gives IDLE and busy=0 after edge k.
- Asserting rst in any state returns the block to reset values immediately (asynchronous). No drain is performed.

## Configuration
- Macro: PRODUCER_CTRL_DRAIN_TIMEOUT_EN.
- Defined:
  - A drain counter clears on DRAIN entry and increments each DRAIN cycle.
  - If the counter reaches TO_CYCLES-1 without the empty condition, the block goes to IDLE and pulses drain_timeout for exactly one cycle, the cycle after that edge.
  - If empty and the timeout coincide on the same edge, the empty exit takes priority and there is no pulse.
- Undefined: there is no counter, DRAIN waits indefinitely, and drain_timeout is tied 0.

## Structure
- Package producer_ctrl_pkg holds:
  - the state typedef with encodings IDLE=2'd0, RUN=2'd1, WAIT=2'd2, DRAIN=2'd3;
  - a clog2-based index-width function.
- Sub-module start_decode (combinational): maps the start vector to a single-hot flag plus a CW-bit index.

## Test plan
- N_CH=2. Pulse start=2'b01 → en=01 and active_ch=0 the next cycle. With ch_valid[0] high, wr_data tracks ch_data[15:0] and wr_en=1.
- In RUN, raise buffer_full for 5 cycles → WAIT, en=00 for those cycles. Drop buffer_full → RUN and en=01 one cycle later.
- start=2'b11 in IDLE → state stays IDLE, en=00. Pulse start=2'b10 while in RUN → ignored, active_ch unchanged.
- stop and buffer_full in the same cycle from RUN → DRAIN, not WAIT. Hold data_valid=1 with buffer_empty=1 → stays in DRAIN. Drop data_valid → IDLE, busy=0.
- With the macro and TO_CYCLES=8, hold buffer_empty=0 in DRAIN → IDLE after 8 DRAIN cycles with a one-cycle drain_timeout pulse. Without the macro → remains in DRAIN.
- Assert rst mid-RUN with N_CH=4 and active_ch=3 → en=0000, active_ch=0, state IDLE asynchronously.
